// File: rtl/bus_dec.sv
// ---------------------------------------------------------------------------
// bus_dec -- CPU bus address decoder and response multiplexer
//
// Decodes the master word address against NUM_SLV base/mask pairs, strobes
// the lowest-index matching slave and returns its read data and acknowledge
// with zero added latency. Accesses to unmapped addresses, and accesses that
// a slave fails to acknowledge within TMO_CYC cycles, are terminated with an
// error acknowledge (bus_ack & bus_err) so the CPU never hangs.
//
// State table:
//   state  | meaning
//   IDLE   | no access outstanding, new strobes are decoded here
//   BUSY   | selected slave has not yet acknowledged, timeout counter runs
//   ERR    | one-cycle error acknowledge to the master
//
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   bus_stb/bus_addr  master strobe and word address
//   bus_din           read data to master (0 when nothing selected / error)
//   bus_ack/bus_err   acknowledge and error qualifier to master
//   slv_stb           one-hot slave strobes
//   slv_dout/slv_ack  packed slave read data and slave acknowledges
//   err_clr/err_irq   clear pulse and sticky bus-error interrupt
//   err_addr          address of the most recent errored access
//
// Build option: define BUS_DEC_ERRADDR_EN to build the err_addr capture
// register; otherwise err_addr is tied to 0.
// ---------------------------------------------------------------------------
module bus_dec #(
    parameter int                     NUM_SLV  = 8,
    parameter int                     AW       = 22,
    parameter logic [NUM_SLV*AW-1:0]  SLV_BASE = '0,
    parameter logic [NUM_SLV*AW-1:0]  SLV_MASK = '0,
    parameter int                     CNT_W    = 8,
    parameter int                     TMO_CYC  = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    bus_stb,
    input  logic [AW-1:0]           bus_addr,
    output logic [31:0]             bus_din,
    output logic                    bus_ack,
    output logic                    bus_err,
    output logic [NUM_SLV-1:0]      slv_stb,
    input  logic [NUM_SLV*32-1:0]   slv_dout,
    input  logic [NUM_SLV-1:0]      slv_ack,
    input  logic                    err_clr,
    output logic                    err_irq,
    output logic [AW-1:0]           err_addr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_irq_q, err_irq_d;

    logic [NUM_SLV-1:0] sel_oh;
    logic               hit;
    logic               ack_sel;
    logic [31:0]        din_sel;

    // Lowest-index match wins; the first hit blocks all higher slots.
    always_comb begin
        sel_oh = '0;
        hit    = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (!hit && ((bus_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW])) begin
                sel_oh[i] = 1'b1;
                hit       = 1'b1;
            end
        end
    end

    // AND-OR response mux; sel_oh is one-hot or zero, so no priority needed.
    always_comb begin
        din_sel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            din_sel = din_sel | (slv_dout[i*32 +: 32] & {32{sel_oh[i]}});
        end
        ack_sel = |(slv_ack & sel_oh);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus_stb) begin
                    if (!hit) begin
                        state_d = S_ERR;
                    end else if (!ack_sel) begin
                        state_d = S_BUSY;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            S_BUSY: begin
                if (ack_sel || !bus_stb) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_ERR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ERR: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Set on entry to ERR dominates a simultaneous clear.
    assign err_irq_d = (state_d == S_ERR) | (err_irq_q & ~err_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            err_irq_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_irq_q <= err_irq_d;
        end
    end

`ifdef BUS_DEC_ERRADDR_EN
    logic [AW-1:0] err_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr_q <= '0;
        end else if (state_d == S_ERR) begin
            err_addr_q <= bus_addr;
        end
    end

    assign err_addr = err_addr_q;
`else
    assign err_addr = '0;
`endif

    // Combinational outputs are gated with rst_n so that everything reads 0
    // while reset is held, even though the response path bypasses the flops.
    logic in_err;
    assign in_err  = (state_q == S_ERR);

    assign slv_stb = (rst_n && bus_stb && !in_err) ? sel_oh : '0;
    assign bus_ack = rst_n & (in_err | ack_sel);
    assign bus_err = rst_n & in_err;
    assign bus_din = (rst_n && !in_err) ? din_sel : 32'd0;
    assign err_irq = err_irq_q;

endmodule

// File: doc/bus_dec.md
Name: bus_dec

Overview:
Parametrised bus address decoder and response multiplexer for the single-master CPU bus. It drives a strobe to one of NUM_SLV slaves, returns that slave's read data and acknowledge, and adds bus-error handling: unmapped accesses and slave timeouts end with an error acknowledge instead of hanging the CPU. It sits between the CPU bus port and all memory and I/O slaves in the top level, replacing the hard-wired decode.

Parameters:
NUM_SLV, 8, number of slave channels (1..16)
AW, 22, word-address width (bus_addr[AW+1:2])
SLV_BASE, {NUM_SLV*AW}'b0, packed per-slave base word address; slot i = bits [i*AW +: AW]
SLV_MASK, {NUM_SLV*AW}'b0, packed per-slave compare mask; slave i matches when (bus_addr & mask_i) == base_i
TMO_CYC, 255, cycles a selected slave may take to acknowledge (2..2^CNT_W-1)
CNT_W, 8, timeout counter width

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
bus_stb  in  1  master strobe
bus_addr  in  AW  master word address
bus_din  out  32  read data to master
bus_ack  out  1  acknowledge to master
bus_err  out  1  error qualifier, valid only with bus_ack
slv_stb  out  NUM_SLV  one-hot slave strobes
slv_dout  in  NUM_SLV*32  packed slave read data, slot i = [i*32 +: 32]
slv_ack  in  NUM_SLV  slave acknowledges
err_clr  in  1  pulse that clears err_irq
err_irq  out  1  sticky bus-error interrupt request
err_addr  out  AW  address of the most recent errored access (optional feature)

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, counter 0, err_irq 0, err_addr 0. All outputs are 0 while rst_n is low. Reset in the middle of an access aborts it with no ack.
- Decode: combinational. sel = lowest index i whose match condition holds. hit = at least one slave matches.
- slv_stb[sel] = bus_stb & hit & (state != ERR). All other slave strobes are 0. At most one strobe is ever high.
- Normal path is combinational and adds zero latency: bus_ack = slv_ack[sel], bus_din = slv_dout[sel], bus_err = 0. When no slave is selected, bus_din = 0.
- FSM states: IDLE, BUSY, ERR.
  - IDLE: when bus_stb & hit & !slv_ack[sel], go to BUSY with cnt = 1. When bus_stb & hit & slv_ack[sel], stay in IDLE (single-cycle access). When bus_stb & !hit, go to ERR.
  - BUSY: when slv_ack[sel], go to IDLE with cnt = 0. When bus_stb drops, go to IDLE (master abort, no error). When cnt == TMO_CYC-1 without an ack, go to ERR. Otherwise cnt increments.
  - ERR: one cycle only. bus_ack = 1, bus_err = 1, bus_din = 0, slv_stb all 0. err_irq is set. The next state is always IDLE.
- Resulting latencies:
  - Unmapped access: error ack in the cycle after the strobe is first seen.
  - Timeout: error ack TMO_CYC cycles after the strobe is first seen.
  - A slave ack in the cycle where cnt reaches TMO_CYC-1 wins: normal ack, no error.
- Back-to-back accesses: after any ack the master may hold bus_stb for a new access. The new access is evaluated from IDLE in the following cycle.
- bus_addr change while BUSY is a protocol violation. Decode follows the live address and the counter keeps running.
- err_irq: set on entry to ERR, cleared by err_clr. When set and clear happen in the same cycle, set wins.

Optional Feature:
BUS_DEC_ERRADDR_EN:
- Defined: err_addr captures bus_addr on entry to ERR and holds it until the next error or reset.
- Undefined: err_addr is tied to 0 and the capture register is not built.

Test Plan:
- Slave 2 with base 0x3F8000 and mask 0x3F8000; access at 0x3F8010 with slv_ack[2] tied high -> slv_stb = 0x04, bus_ack in the same cycle, bus_err 0, bus_din = slv_dout slot 2.
- Overlapping slaves 0 and 3 both matching 0x000100 -> only slv_stb[0] asserts and data comes from slot 0.
- Unmapped address 0x3FFF00 -> no slv_stb; bus_ack & bus_err exactly one cycle after bus_stb; bus_din 0; err_irq rises; err_addr = 0x3FFF00 with BUS_DEC_ERRADDR_EN defined.
- TMO_CYC = 4; slave never acknowledges -> slv_stb high for cycles 0-3, error ack in cycle 4 with slv_stb low; with slv_ack in cycle 3 instead -> normal ack, no error.
- err_irq set and err_clr pulsed in the same cycle as a new error -> err_irq stays 1; a later lone err_clr -> err_irq goes to 0.
- rst_n driven low while in BUSY -> all outputs 0 immediately without waiting for a clock edge; after release, a fresh access completes normally.
